// File: rtl/apb_slave_regfile.sv
// APB register file: six RW registers, a transfer counter and an ID word.
// Define APB_SLVERR_EN to flag RO writes and unmapped accesses on pslverr.
module apb_slave_regfile #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;

  logic        wr_q;
  logic [5:0]  idx_q;
  logic [31:0] wdata_q;

  logic [31:0] regs [6];
  logic [31:0] xfer_cnt;

  logic        done;
  logic        rw_hit;
  logic        cnt_hit;
  logic        id_hit;
  logic        err;
  logic [31:0] rd_mux;
  logic        unused_ok;

  assign unused_ok = ^{paddr[31:8], paddr[1:0]};

  assign done    = (state == ACCESS) && (cnt == 4'd0);
  assign rw_hit  = (idx_q < 6'd6);
  assign cnt_hit = (idx_q == 6'd6);
  assign id_hit  = (idx_q == 6'd7);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (psel && !penable) state_nxt = SETUP;
      end
      SETUP: begin
        state_nxt = ACCESS;
        cnt_nxt   = 4'(WAIT_STATES);
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          if (psel && !penable) state_nxt = SETUP;
          else                  state_nxt = IDLE;
        end else if (!psel) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      rw_hit:  rd_mux = regs[idx_q[2:0]];
      cnt_hit: rd_mux = xfer_cnt;
      id_hit:  rd_mux = ID_VALUE;
      default: rd_mux = '0;
    endcase
  end

`ifdef APB_SLVERR_EN
  assign err = !(rw_hit || cnt_hit || id_hit) ||
               (wr_q && (cnt_hit || id_hit));
`else
  assign err = 1'b0;
`endif

  // Gating with hreset keeps outputs quiet even if reset lands mid-ACCESS.
  assign pready  = !hreset && done;
  assign prdata  = (pready && !wr_q) ? rd_mux : '0;
  assign pslverr = pready && err;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      xfer_cnt <= '0;
      for (int i = 0; i < 6; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == SETUP) begin
        wr_q    <= pwrite;
        idx_q   <= paddr[7:2];
        wdata_q <= pwdata;
      end
      if (done) begin
        xfer_cnt <= xfer_cnt + 32'd1;
        if (wr_q && rw_hit) regs[idx_q[2:0]] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile with three wait-state settings.
// Instance 0: WAIT_STATES=0, instance 1: 3, instance 2: 2.
module tb_apb_slave_regfile;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic [2:0]  psel_v = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata_v [3];
  logic [2:0]  pready_v;
  logic [2:0]  pslverr_v;

  int checks = 0;
  int errors = 0;

`ifdef APB_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  localparam logic [31:0] ID = 32'hA5B0_0001;

  always #5 hclk = ~hclk;

  apb_slave_regfile #(.WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset), .psel(psel_v[0]),
    .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata_v[0]),
    .pready(pready_v[0]), .pslverr(pslverr_v[0])
  );

  apb_slave_regfile #(.WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hreset(hreset), .psel(psel_v[1]),
    .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata_v[1]),
    .pready(pready_v[1]), .pslverr(pslverr_v[1])
  );

  apb_slave_regfile #(.WAIT_STATES(2)) u_ws2 (
    .hclk(hclk), .hreset(hreset), .psel(psel_v[2]),
    .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata_v[2]),
    .pready(pready_v[2]), .pslverr(pslverr_v[2])
  );

  // lat = cycles from the SETUP cycle to the pready cycle
  task automatic xfer(input int k, input bit wr,
                      input logic [31:0] addr,
                      input logic [31:0] wd,
                      output logic [31:0] rd,
                      output bit err, output int lat);
    rd  = '0;
    err = 1'b0;
    lat = -1;
    @(negedge hclk);
    psel_v    = '0;
    psel_v[k] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = addr;
    pwdata    = wd;
    for (int i = 0; i < 40; i++) begin
      @(negedge hclk);
      penable = 1'b1;
      #1;
      if (pready_v[k]) begin
        lat = i;
        rd  = prdata_v[k];
        err = pslverr_v[k];
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d addr %h", k, addr);
    end
  endtask

  task automatic go_idle();
    @(negedge hclk);
    psel_v  = '0;
    penable = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge hclk);
    hreset  = 1'b1;
    psel_v  = '0;
    penable = 1'b0;
    @(negedge hclk);
    hreset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    bit          err;
    int          lat;
    @(negedge hclk);
    psel_v  = '0;
    penable = 1'b0;
    #1;
    checks++;
    if ({pready_v, pslverr_v} !== 6'b0) begin
      errors++;
      $display("FAIL rst_hold rdy/err got %b exp 0",
               {pready_v, pslverr_v});
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (prdata_v[k] !== 32'h0) begin
        errors++;
        $display("FAIL rst_prdata%0d got %h exp 0", k, prdata_v[k]);
      end
    end
    @(negedge hclk);
    hreset = 1'b0;
    #1;
    checks++;
    if ({pready_v, pslverr_v} !== 6'b0) begin
      errors++;
      $display("FAIL rst_after rdy/err got %b exp 0",
               {pready_v, pslverr_v});
    end
    xfer(0, 1'b0, 32'h00, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL rst_reg0 got %h exp 0", rd);
    end
    xfer(0, 1'b0, 32'h18, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL rst_cnt got %h exp 1", rd);
    end
  endtask

  task automatic test_rw_ws0();
    logic [31:0] rd;
    bit          err;
    int          lat;
    apply_reset();
    xfer(0, 1'b1, 32'h04, 32'h0000_1234, rd, err, lat);
    checks++;
    if (lat !== 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL ws0_wr lat %0d err %b exp 1 0", lat, err);
    end
    xfer(0, 1'b0, 32'h04, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0000_1234 || lat !== 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL ws0_rd got %h lat %0d err %b exp 1234 1 0",
               rd, lat, err);
    end
    xfer(0, 1'b0, 32'h07, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0000_1234) begin
      errors++;
      $display("FAIL ws0_lowbits got %h exp 1234", rd);
    end
    xfer(0, 1'b1, 32'h14, 32'hCAFE_0005, rd, err, lat);
    xfer(0, 1'b0, 32'h14, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'hCAFE_0005) begin
      errors++;
      $display("FAIL ws0_reg5 got %h exp cafe0005", rd);
    end
    xfer(0, 1'b0, 32'h00, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL ws0_reg0 got %h exp 0", rd);
    end
    xfer(0, 1'b0, 32'h18, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'd6) begin
      errors++;
      $display("FAIL ws0_cnt got %h exp 6", rd);
    end
    go_idle();
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    bit          err;
    int          lat;
    xfer(1, 1'b0, 32'h1C, 32'h0, rd, err, lat);
    checks++;
    if (rd !== ID || lat !== 4 || err !== 1'b0) begin
      errors++;
      $display("FAIL ws3_id got %h lat %0d err %b exp %h 4 0",
               rd, lat, err, ID);
    end
    xfer(1, 1'b1, 32'h08, 32'h0BAD_F00D, rd, err, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL ws3_wr lat %0d exp 4", lat);
    end
    xfer(1, 1'b0, 32'h08, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL ws3_reg2 got %h exp 0badf00d", rd);
    end
    go_idle();
  endtask

  task automatic test_slverr();
    logic [31:0] rd;
    bit          err;
    int          lat;
    apply_reset();
    xfer(0, 1'b1, 32'h1C, 32'hFFFF_FFFF, rd, err, lat);
    checks++;
    if (err !== SLV) begin
      errors++;
      $display("FAIL err_wr_id got %b exp %b", err, SLV);
    end
    xfer(0, 1'b0, 32'h1C, 32'h0, rd, err, lat);
    checks++;
    if (rd !== ID || err !== 1'b0) begin
      errors++;
      $display("FAIL err_id_kept got %h err %b exp %h 0", rd, err, ID);
    end
    xfer(0, 1'b0, 32'h40, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0 || err !== SLV) begin
      errors++;
      $display("FAIL err_rd_unmap got %h err %b exp 0 %b", rd, err, SLV);
    end
    xfer(0, 1'b1, 32'h18, 32'h0000_1234, rd, err, lat);
    checks++;
    if (err !== SLV) begin
      errors++;
      $display("FAIL err_wr_cnt got %b exp %b", err, SLV);
    end
    xfer(0, 1'b1, 32'h80, 32'h0000_0077, rd, err, lat);
    checks++;
    if (err !== SLV) begin
      errors++;
      $display("FAIL err_wr_unmap got %b exp %b", err, SLV);
    end
    xfer(0, 1'b0, 32'h18, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'd5 || err !== 1'b0) begin
      errors++;
      $display("FAIL err_cnt got %h err %b exp 5 0", rd, err);
    end
    xfer(0, 1'b0, 32'h00, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL err_reg0 got %h exp 0", rd);
    end
    go_idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    bit          err;
    int          lat;
    apply_reset();
    @(negedge hclk);
    psel_v[2] = 1'b1;
    penable   = 1'b0;
    pwrite    = 1'b1;
    paddr     = 32'h00;
    pwdata    = 32'hDEAD_BEEF;
    @(negedge hclk);
    penable = 1'b1;
    #1;
    checks++;
    if (pready_v[2] !== 1'b0) begin
      errors++;
      $display("FAIL abort_setup rdy got %b exp 0", pready_v[2]);
    end
    @(negedge hclk);
    #1;
    checks++;
    if (pready_v[2] !== 1'b0) begin
      errors++;
      $display("FAIL abort_acc1 rdy got %b exp 0", pready_v[2]);
    end
    @(negedge hclk);
    psel_v  = '0;
    penable = 1'b0;
    #1;
    checks++;
    if (pready_v[2] !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop rdy got %b exp 0", pready_v[2]);
    end
    xfer(2, 1'b0, 32'h18, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0 || lat !== 3) begin
      errors++;
      $display("FAIL abort_cnt got %h lat %0d exp 0 3", rd, lat);
    end
    xfer(2, 1'b0, 32'h00, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL abort_reg0 got %h exp 0", rd);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bit          err;
    int          lat;
    apply_reset();
    xfer(1, 1'b1, 32'h04, 32'h0000_0055, rd, err, lat);
    xfer(1, 1'b0, 32'h04, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h55) begin
      errors++;
      $display("FAIL rmid_reg1 got %h exp 55", rd);
    end
    @(negedge hclk);
    psel_v[1] = 1'b1;
    penable   = 1'b0;
    pwrite    = 1'b1;
    paddr     = 32'h08;
    pwdata    = 32'h0000_0077;
    @(negedge hclk);
    penable = 1'b1;
    @(negedge hclk);
    #1;
    checks++;
    if (pready_v[1] !== 1'b0) begin
      errors++;
      $display("FAIL rmid_acc rdy got %b exp 0", pready_v[1]);
    end
    @(negedge hclk);
    hreset  = 1'b1;
    psel_v  = '0;
    penable = 1'b0;
    #1;
    checks++;
    if (pready_v[1] !== 1'b0 || pslverr_v[1] !== 1'b0) begin
      errors++;
      $display("FAIL rmid_inrst rdy %b err %b exp 0 0",
               pready_v[1], pslverr_v[1]);
    end
    @(negedge hclk);
    hreset = 1'b0;
    #1;
    checks++;
    if (pready_v[1] !== 1'b0 || prdata_v[1] !== 32'h0) begin
      errors++;
      $display("FAIL rmid_after rdy %b data %h exp 0 0",
               pready_v[1], prdata_v[1]);
    end
    xfer(1, 1'b0, 32'h18, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0 || lat !== 4) begin
      errors++;
      $display("FAIL rmid_cnt got %h lat %0d exp 0 4", rd, lat);
    end
    xfer(1, 1'b0, 32'h04, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL rmid_reg1_clr got %h exp 0", rd);
    end
    xfer(1, 1'b0, 32'h08, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL rmid_reg2 got %h exp 0", rd);
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    bit          err;
    int          lat;
    bit          wrs [3];
    logic [31:0] adr [3];
    logic [31:0] wds [3];
    logic [31:0] exp [3];
    wrs[0] = 1'b1; adr[0] = 32'h08; wds[0] = 32'h11; exp[0] = 32'h0;
    wrs[1] = 1'b0; adr[1] = 32'h08; wds[1] = 32'h0;  exp[1] = 32'h11;
    wrs[2] = 1'b0; adr[2] = 32'h18; wds[2] = 32'h0;  exp[2] = 32'h2;
    apply_reset();
    @(negedge hclk);
    psel_v[0] = 1'b1;
    penable   = 1'b0;
    pwrite    = wrs[0];
    paddr     = adr[0];
    pwdata    = wds[0];
    for (int t = 0; t < 3; t++) begin
      @(negedge hclk);
      penable = 1'b1;
      #1;
      checks++;
      if (pready_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_setup%0d rdy got %b exp 0", t, pready_v[0]);
      end
      @(negedge hclk);
      #1;
      checks++;
      if (pready_v[0] !== 1'b1 || prdata_v[0] !== exp[t]) begin
        errors++;
        $display("FAIL b2b_done%0d rdy %b data %h exp 1 %h",
                 t, pready_v[0], prdata_v[0], exp[t]);
      end
      if (t < 2) begin
        penable = 1'b0;
        pwrite  = wrs[t+1];
        paddr   = adr[t+1];
        pwdata  = wds[t+1];
      end
    end
    go_idle();
    xfer(0, 1'b0, 32'h18, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h3) begin
      errors++;
      $display("FAIL b2b_cnt got %h exp 3", rd);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_rw_ws0();
    test_wait_states();
    test_slverr();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    go_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 Parameter WAIT_STATES, default 0: access-phase wait cycles before pready, range 0..15; 0 is required when the APB initiator does not sample pready.
REQ-002 Parameter ID_VALUE, default 32'hA5B0_0001: constant returned by the ID register.
REQ-003 hclk  input  1  single clock; all logic updates on rising edge.
REQ-004 hreset  input  1  reset, synchronous, active-high.
REQ-005 psel  input  1  slave select from APB initiator.
REQ-006 penable  input  1  APB access-phase strobe.
REQ-007 pwrite  input  1  1 = write, 0 = read.
REQ-008 paddr  input  32  byte address; only paddr[7:2] decoded, paddr[1:0] ignored.
REQ-009 pwdata  input  32  write data.
REQ-010 prdata  output  32  read data; valid only in the cycle pready=1 of a read, otherwise 0.
REQ-011 pready  output  1  transfer completion.
REQ-012 pslverr  output  1  error response, valid only with pready=1.

Function
REQ-013 FSM states: IDLE, SETUP, ACCESS.
REQ-014 IDLE->SETUP when psel=1 and penable=0; psel=1 with penable=1 in IDLE is ignored (stay IDLE, pready=0).
REQ-015 SETUP: latch pwrite, paddr[7:2], pwdata; load wait counter with WAIT_STATES; next state ACCESS unconditionally.
REQ-016 ACCESS: counter nonzero -> decrement, pready=0; counter zero -> pready=1 that cycle (combinational from state and counter).
REQ-017 Completion cycle (ACCESS, pready=1): write commits at the clock edge; next state SETUP if psel=1 and penable=0, else IDLE.
REQ-018 psel=0 during ACCESS before completion: abort to IDLE, no write, no counter increment, pready=0.
REQ-019 Register map (word offsets): 0x00-0x14 REG0-REG5 RW, reset 0; 0x18 XFER_CNT RO; 0x1C ID RO = ID_VALUE; 0x20-0xFC unmapped.
REQ-020 XFER_CNT increments by 1 on every completed transfer (read or write, including errored), 32-bit, wraps 0xFFFF_FFFF->0; a read of XFER_CNT returns the value before its own increment.
REQ-021 Writes to RO or unmapped offsets do not modify any register.
REQ-022 Reads of unmapped offsets return 0.
REQ-023 Latency with WAIT_STATES=N: pready asserted exactly N+1 cycles after the SETUP cycle (N=0: first ACCESS cycle).

Reset
REQ-024 hreset=1 at a rising edge forces state IDLE, counter 0, REG0-REG5 0, XFER_CNT 0.
REQ-025 While in reset and the first cycle after: pready=0, pslverr=0, prdata=0.
REQ-026 Reset during SETUP or ACCESS aborts the transfer with no write and no XFER_CNT increment.

Configuration
REQ-027 Macro APB_SLVERR_EN defined: pslverr=1 in the completion cycle of any write to 0x18/0x1C or any access to an unmapped offset; 0 otherwise.
REQ-028 Macro APB_SLVERR_EN undefined: pslverr tied 0; the RO/unmapped behaviour of REQ-021/REQ-022 is unchanged.

Verification
REQ-029 WAIT_STATES=0: write 0x0000_1234 to 0x04, then read 0x04 -> pready high in each first ACCESS cycle, prdata=0x0000_1234, pslverr=0.
REQ-030 WAIT_STATES=3: read 0x1C -> pready low for 3 ACCESS cycles, high on the 4th with prdata=0xA5B0_0001.
REQ-031 APB_SLVERR_EN defined: write 0xFFFF_FFFF to 0x1C and read 0x40 -> pslverr=1 on both completions, ID unchanged, read prdata=0; undefined: pslverr=0 for both.
REQ-032 WAIT_STATES=2: psel dropped after 1 ACCESS cycle of write 0xDEAD_BEEF to 0x00 -> REG0 stays 0, XFER_CNT unchanged, FSM in IDLE.
REQ-033 Assert hreset mid-ACCESS after REG1 written 0x55 -> REG1=0, XFER_CNT=0, pready=0; next transfer completes normally.
REQ-034 Back-to-back: 3 transfers with SETUP issued in each completion cycle -> XFER_CNT read in the 3rd transfer returns 2; no idle cycle required between transfers.
